// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// State names follow the release order of the sequence.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        REL_PERIPH,
        RUN
    } state_e;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65535;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_STAGE_GAP      = 64;
    localparam int DEF_MAX_RETRIES    = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Bundle of the sequencer's lock input and reset outputs.
// master = sequencer side, slave = PLL/system side.
interface pll_reset_seq_if;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       pll_rst;
    logic       periph_rst_n;
    logic       cpu_rst_n;
    logic       sys_ready;
    logic       lock_fail;
    logic [2:0] retry_cnt;

    modport master (
        input  pll_locked, sw_rst_req,
        output pll_rst, periph_rst_n, cpu_rst_n,
        output sys_ready, lock_fail, retry_cnt
    );

    modport slave (
        output pll_locked, sw_rst_req,
        input  pll_rst, periph_rst_n, cpu_rst_n,
        input  sys_ready, lock_fail, retry_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Resets to 0 so an unknown input reads as deasserted.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the async level through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, proves lock,
// then releases peripheral and CPU resets in order.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP      = DEF_STAGE_GAP,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic       pll_rst,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic       sys_ready,
    output logic       lock_fail,
    output logic [2:0] retry_cnt
);

    localparam int CMAX = max_int(
        max_int(PLL_RST_CYCLES, LOCK_TIMEOUT),
        max_int(STABLE_CYCLES, STAGE_GAP));
    localparam int CW = $clog2(CMAX) + 1;

    localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] SG_LAST = CW'(STAGE_GAP - 1);
    localparam logic [2:0]    MR      =
        3'((MAX_RETRIES > 7) ? 7 : MAX_RETRIES);

    logic          lk_s;
    logic          drop;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    retry_q, retry_d;
    logic          fail_q, fail_d;
    logic          pll_rst_q, pll_rst_d;
    logic          periph_q, periph_d;
    logic          cpu_q, cpu_d;
    logic          ready_q, ready_d;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Next state, counter reload and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        retry_d = retry_q;
        fail_d  = fail_q;
        drop    = sw_rst_req || !lk_s;

        unique case (state_q)
            PLL_RST: begin
                if (cnt_q >= PR_LAST)
                    state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (sw_rst_req) begin
                    state_d = PLL_RST;
                end else if (lk_s) begin
                    state_d = STABLE;
                end else if (cnt_q >= LT_LAST) begin
                    state_d = PLL_RST;
                    if (retry_q != 3'd7)
                        retry_d = retry_q + 3'd1;
                    if (retry_d == MR)
                        fail_d = 1'b1;
                end
            end
            STABLE: begin
                if (sw_rst_req)
                    state_d = PLL_RST;
                else if (!lk_s)
                    state_d = WAIT_LOCK;
                else if (cnt_q >= ST_LAST)
                    state_d = REL_PERIPH;
            end
            REL_PERIPH: begin
                if (drop)
                    state_d = PLL_RST;
                else if (cnt_q >= SG_LAST)
                    state_d = RUN;
            end
            RUN: begin
                if (drop)
                    state_d = PLL_RST;
            end
            default: state_d = PLL_RST;
        endcase

        if (state_d != state_q)
            cnt_d = '0;

        // Reaching RUN proves the PLL good again.
        if (state_d == RUN && state_q != RUN) begin
            retry_d = '0;
            fail_d  = 1'b0;
        end

        pll_rst_d = (state_d == PLL_RST);
        periph_d  = (state_d == REL_PERIPH) || (state_d == RUN);
        cpu_d     = (state_d == RUN);
        ready_d   = (state_d == RUN);
    end

    // State, counters and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            fail_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            periph_q  <= 1'b0;
            cpu_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            fail_q    <= fail_d;
            pll_rst_q <= pll_rst_d;
            periph_q  <= periph_d;
            cpu_q     <= cpu_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign periph_rst_n = periph_q;
    assign cpu_rst_n    = cpu_q;
    assign sys_ready    = ready_q;
    assign lock_fail    = fail_q;
    assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed scenarios with literal timing
// pins plus a randomized run checked every cycle against a model.
module tb_pll_reset_seq;

    localparam int P_RST = 4;
    localparam int P_TO  = 100;
    localparam int P_ST  = 16;
    localparam int P_GAP = 8;
    localparam int P_MR  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pll_reset_seq_if bus ();

    pll_reset_seq #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .STABLE_CYCLES  (P_ST),
        .STAGE_GAP      (P_GAP),
        .MAX_RETRIES    (P_MR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (bus.pll_locked),
        .sw_rst_req   (bus.sw_rst_req),
        .pll_rst      (bus.pll_rst),
        .periph_rst_n (bus.periph_rst_n),
        .cpu_rst_n    (bus.cpu_rst_n),
        .sys_ready    (bus.sys_ready),
        .lock_fail    (bus.lock_fail),
        .retry_cnt    (bus.retry_cnt)
    );

    always #10 clk = ~clk;

    logic [7:0] dut_vec;
    assign dut_vec = {bus.pll_rst, bus.periph_rst_n, bus.cpu_rst_n,
                      bus.sys_ready, bus.lock_fail, bus.retry_cnt};

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Behavioural model: phase index 0..4 walks the release order,
    // m_len is how long the current phase has lasted.
    int   m_ph, m_len, m_retry;
    logic m_fail, m_s1, m_s2;
    int   dur [4] = '{P_RST, P_TO, P_ST, P_GAP};

    task automatic model_reset();
        m_ph = 0; m_len = 0; m_retry = 0;
        m_fail = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_step();
        logic lk;
        int   nx;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.pll_locked;
        nx   = m_ph;
        if ((bus.sw_rst_req && m_ph != 0) || (!lk && m_ph >= 3)) begin
            nx = 0;
        end else begin
            case (m_ph)
                0: if (m_len + 1 >= dur[0]) nx = 1;
                1: if (lk) nx = 2;
                   else if (m_len + 1 >= dur[1]) begin
                       nx = 0;
                       if (m_retry < 7) m_retry++;
                       if (m_retry == P_MR) m_fail = 1'b1;
                   end
                2: if (!lk) nx = 1;
                   else if (m_len + 1 >= dur[2]) nx = 3;
                3: if (m_len + 1 >= dur[3]) nx = 4;
                default: ;
            endcase
        end
        m_len = (nx == m_ph) ? m_len + 1 : 0;
        if (nx == 4 && m_ph != 4) begin
            m_retry = 0;
            m_fail  = 1'b0;
        end
        m_ph = nx;
    endtask

    function automatic logic [7:0] model_vec();
        return {m_ph == 0, m_ph >= 3, m_ph == 4, m_ph == 4,
                m_fail, 3'(m_retry)};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
            else model_reset();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            check("cycle_outputs", dut_vec, model_vec());
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int t_a, t_b, t_c, t_d, n_p;
    int rise_c [10];
    logic [3:0] rise_st [10];
    int nr;
    logic prev;
    int hold;

    initial begin
        bus.pll_locked = 1'b0;
        bus.sw_rst_req = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check("reset_vals", dut_vec, 8'h80);

        // Cold boot, lock raised in cycle 10.
        rst_n = 1'b1;
        t_a = -1; t_b = -1; t_c = -1; t_d = -1;
        for (int c = 0; c < 60; c++) begin
            if (c == 10) bus.pll_locked = 1'b1;
            if (bus.pll_rst) t_a = c;
            if (bus.periph_rst_n && t_b < 0) t_b = c;
            if (bus.cpu_rst_n && t_c < 0) t_c = c;
            if (bus.sys_ready && t_d < 0) t_d = c;
            tick(1);
        end
        check("boot_pll_rst_last", t_a, 3);
        check("boot_periph_rise", t_b, 29);
        check("boot_cpu_rise", t_c, 37);
        check("boot_ready_rise", t_d, 37);

        // Software reset in RUN with lock held.
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        n_p = 0; t_b = -1; t_c = -1;
        for (int c = 1; c <= 50; c++) begin
            if (bus.pll_rst) n_p++;
            if (bus.periph_rst_n && t_b < 0) t_b = c;
            if (bus.cpu_rst_n && t_c < 0) t_c = c;
            tick(1);
        end
        check("sw_pll_rst_len", n_p, 4);
        check("sw_periph_rise", t_b, 22);
        check("sw_cpu_rise", t_c, 30);
        check("sw_retry", bus.retry_cnt, 0);

        // Lock loss in RUN.
        bus.pll_locked = 1'b0;
        t_a = -1; t_b = -1; t_c = -1; t_d = -1; prev = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!bus.cpu_rst_n && t_c < 0) t_c = c;
            if (!bus.periph_rst_n && t_b < 0) t_b = c;
            if (!bus.sys_ready && t_d < 0) t_d = c;
            if (c == 4) prev = bus.pll_rst;
            tick(1);
        end
        check("loss_cpu_fall", t_c, 3);
        check("loss_periph_same", t_b, t_c);
        check("loss_ready_same", t_d, t_c);
        check("loss_pll_rst_next", prev, 1);
        tick(10);

        // One-cycle lock glitch while proving stability.
        t_b = -1;
        for (int c = 0; c < 33; c++) begin
            if (c == 0) bus.pll_locked = 1'b1;
            if (c == 10) bus.pll_locked = 1'b0;
            if (c == 11) bus.pll_locked = 1'b1;
            if (bus.periph_rst_n && t_b < 0) t_b = c;
            tick(1);
        end
        check("glitch_periph_rise", t_b, 30);
        check("glitch_retry", bus.retry_cnt, 0);
        check("glitch_in_rel", {bus.periph_rst_n, bus.cpu_rst_n}, 2'b10);

        // Async reset between edges while releasing peripherals.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec, 8'h80);
        bus.pll_locked = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Lock never arrives.
        nr = 0; prev = 1'b1;
        for (int c = 0; c < 104 * 9 + 5; c++) begin
            if (bus.pll_rst && !prev && nr < 10) begin
                rise_c[nr] = c;
                rise_st[nr] = {bus.lock_fail, bus.retry_cnt};
                nr++;
            end
            prev = bus.pll_rst;
            tick(1);
        end
        check("timeout_count", nr, 9);
        for (int k = 1; k <= 9; k++) begin
            if (k <= nr) begin
                check("timeout_rise", rise_c[k-1], 104 * k);
                check("timeout_status", rise_st[k-1],
                      {k >= 7, 3'((k < 7) ? k : 7)});
            end
        end
        check("fail_sticky", bus.lock_fail, 1);

        // Lock finally arrives: RUN clears the retry status.
        bus.pll_locked = 1'b1;
        for (int c = 0; c < 200 && !bus.sys_ready; c++) tick(1);
        check("relock_ready", bus.sys_ready, 1);
        check("relock_status", {bus.lock_fail, bus.retry_cnt}, 4'h0);

        // Randomized lock activity and software resets.
        for (int i = 0; i < 60; i++) begin
            hold = ($urandom_range(0, 4) == 0) ?
                   $urandom_range(90, 250) : $urandom_range(1, 40);
            bus.pll_locked = ($urandom_range(0, 2) != 0);
            for (int j = 0; j < hold; j++) begin
                bus.sw_rst_req = ($urandom_range(0, 149) == 0);
                tick(1);
            end
        end
        bus.sw_rst_req = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
